// File: rtl/apb_pulse_gen_if.sv
// APB bus bundle for apb_pulse_gen: 4-bit byte address, 32-bit data, wait-state capable.
interface apb_pulse_gen_if;
  logic [3:0]  paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_pulse_gen.sv
// APB slave driving NUM_CH programmable-length pulse channels, a read strobe,
// per-channel busy status and sticky overrun flags with an interrupt.
module apb_pulse_gen #(
  parameter int NUM_CH  = 8,
  parameter int LEN_W   = 8,
  parameter int WAIT_ST = 0
) (
  input  logic                pclk,
  input  logic                reset,
  input  logic                enable,
  apb_pulse_gen_if.slave      apb,
  output logic [NUM_CH-1:0]   pulse_out,
  output logic                read_pulse,
  output logic                irq
);

  localparam logic [1:0] WAIT_L    = 2'(WAIT_ST);
  localparam logic [1:0] ADDR_TRIG = 2'd0;
  localparam logic [1:0] ADDR_LEN  = 2'd1;
  localparam logic [1:0] ADDR_RSTB = 2'd2;
  localparam logic [1:0] ADDR_OVR  = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ch_state_t;

  ch_state_t         r_state [NUM_CH];
  logic [LEN_W-1:0]  r_cnt   [NUM_CH];
  logic [NUM_CH-1:0] r_pulse;
  logic [LEN_W-1:0]  r_len;
  logic [NUM_CH-1:0] r_ovr;
  logic              r_irq;
  logic              r_read_pulse;
  logic [1:0]        r_wait;

  logic              w_pready;
  logic              w_done;
  logic              w_err;
  logic              w_wr;
  logic              w_rd;
  logic [1:0]        w_sel;
  logic [NUM_CH-1:0] w_trig;
  logic [NUM_CH-1:0] w_ovr_clr;
  logic [NUM_CH-1:0] w_ovr_set;
  logic [NUM_CH-1:0] w_ovr_nxt;
  logic              w_len_wr;
  logic              w_rstb_rd;
  logic [31:0]       w_busy32;
  logic [31:0]       w_len32;
  logic [31:0]       w_ovr32;
  logic [31:0]       w_prdata;
  logic              w_unused_bits;

  // pready only rises once the wait counter has covered WAIT_ST access cycles;
  // enable=0 holds it low so transfers stall instead of completing.
  assign w_pready = enable & (r_wait == WAIT_L);
  assign w_done   = apb.psel & apb.penable & w_pready;
  assign w_sel    = apb.paddr[3:2];

  // transfer decode; an error completion carries no side effects
  always_comb begin
    w_err     = 1'b0;
    w_wr      = 1'b0;
    w_rd      = 1'b0;
    w_trig    = '0;
    w_ovr_clr = '0;
    w_len_wr  = 1'b0;
    w_rstb_rd = 1'b0;
    if (w_done) begin
      w_err = (apb.paddr[1:0] != 2'b00);
      w_wr  = ~w_err & apb.pwrite;
      w_rd  = ~w_err & ~apb.pwrite;
    end else begin
      w_err = 1'b0;
    end
    if (w_wr) begin
      case (w_sel)
        ADDR_TRIG: w_trig    = apb.pwdata[NUM_CH-1:0];
        ADDR_LEN:  w_len_wr  = 1'b1;
        ADDR_OVR:  w_ovr_clr = apb.pwdata[NUM_CH-1:0];
        default:   w_len_wr  = 1'b0;
      endcase
    end else begin
      w_len_wr = 1'b0;
    end
    if (w_rd && (w_sel == ADDR_RSTB)) begin
      w_rstb_rd = 1'b1;
    end else begin
      w_rstb_rd = 1'b0;
    end
  end

  // a trigger landing on an active channel is an overrun; set beats clear
  assign w_ovr_set = w_trig & r_pulse;
  assign w_ovr_nxt = (r_ovr & ~w_ovr_clr) | w_ovr_set;

  // zero-extended views of the narrow registers for the read mux
  always_comb begin
    w_busy32               = 32'd0;
    w_len32                = 32'd0;
    w_ovr32                = 32'd0;
    w_busy32[NUM_CH-1:0]   = r_pulse;
    w_len32[LEN_W-1:0]     = r_len;
    w_ovr32[NUM_CH-1:0]    = r_ovr;
  end

  // combinational read data, valid whenever a read is selected
  always_comb begin
    w_prdata = 32'd0;
    if (apb.psel && !apb.pwrite) begin
      case (w_sel)
        ADDR_TRIG: w_prdata = w_busy32;
        ADDR_LEN:  w_prdata = w_len32;
        ADDR_RSTB: w_prdata = 32'd0;
        ADDR_OVR:  w_prdata = w_ovr32;
        default:   w_prdata = 32'd0;
      endcase
    end else begin
      w_prdata = 32'd0;
    end
  end

  // wait counter runs through the access phase and restarts per transfer
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_wait <= 2'd0;
    end else if (enable) begin
      if (!apb.psel || w_done) begin
        r_wait <= 2'd0;
      end else if (apb.penable) begin
        r_wait <= r_wait + 2'd1;
      end else begin
        r_wait <= 2'd0;
      end
    end
  end

  // control/status registers and the read strobe
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_len        <= '0;
      r_ovr        <= '0;
      r_irq        <= 1'b0;
      r_read_pulse <= 1'b0;
    end else if (enable) begin
      if (w_len_wr) begin
        r_len <= apb.pwdata[LEN_W-1:0];
      end
      r_ovr        <= w_ovr_nxt;
      r_irq        <= |w_ovr_nxt;
      r_read_pulse <= w_rstb_rd;
    end
  end

  // per-channel pulse FSM; a retrigger reloads the count so the pulse extends
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_pulse <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
    end else if (enable) begin
      for (int i = 0; i < NUM_CH; i++) begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_trig[i]) begin
              r_state[i] <= ST_ACTIVE;
              r_cnt[i]   <= r_len;
              r_pulse[i] <= 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (w_trig[i]) begin
              r_cnt[i] <= r_len;
            end else if (r_cnt[i] == '0) begin
              r_state[i] <= ST_IDLE;
              r_pulse[i] <= 1'b0;
            end else begin
              r_cnt[i] <= r_cnt[i] - LEN_W'(1);
            end
          end
          default: begin
            r_state[i] <= ST_IDLE;
            r_cnt[i]   <= '0;
            r_pulse[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign apb.prdata  = w_prdata;
  assign apb.pready  = w_pready;
  assign apb.pslverr = w_err;
  assign pulse_out   = r_pulse;
  assign read_pulse  = r_read_pulse;
  assign irq         = r_irq;

  assign w_unused_bits = ^apb.pwdata;

endmodule
